cpu_seg_display: RTL and testbench
==================================

Name: cpu_seg_display

Overview:
- Consumer end of the CPU's status outputs (`display`, `cycle_count`, `halt`).
- Drives an 8-digit, common-anode, multiplexed seven-segment display on the board.
- Shows either the syscall display value or the cycle count as 8 hex digits.
- Latches the halt event and freezes both values at that moment.
- Snapshots the shown value once per scan frame, so digits never tear mid-frame.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit; legal range is 1 or more.

Ports:
- clk  input  1  system clock.
- clr  input  1  asynchronous reset, active-low.
- display  input  32  syscall display value from the CPU.
- cycle_count  input  32  cycle counter from the CPU.
- halt  input  1  CPU halt flag; may be a level or a pulse.
- mode  input  1  0 shows `display`; 1 shows `cycle_count`.
- an  output  8  digit anodes, active-low, one-hot; an[0] is the rightmost digit.
- seg  output  8  segment cathodes, active-low; seg[6:0] = g,f,e,d,c,b,a and seg[7] = dp.
- halted  output  1  sticky halt indicator.

Behaviour:
- Reset:
  - Asynchronous on clr low, released synchronously to clk.
  - All internal registers clear to 0: div_cnt, digit_idx, shown, frozen_disp, frozen_cyc, halt_lat.
  - Outputs: an = 8'hFF, seg = 8'hFF, halted = 0.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where div_cnt == REFRESH_DIV-1.
  - With REFRESH_DIV = 1, tick is asserted every cycle.
- Scan:
  - On tick, digit_idx increments modulo 8 (7 wraps to 0).
  - frame_start = tick && digit_idx == 7.
- Halt latch:
  - In any cycle with halt = 1 and halt_lat = 0:
    - halt_lat <= 1
    - frozen_disp <= display
    - frozen_cyc <= cycle_count
  - Later halt pulses are ignored; halt_lat clears only on reset.
  - halted = halt_lat, registered; it asserts one cycle after halt is first sampled high.
- Source select: src = halt_lat ? (mode ? frozen_cyc : frozen_disp) : (mode ? cycle_count : display).
- Snapshot:
  - On frame_start, shown <= src. There is no other update path.
  - A change on mode, display or cycle_count mid-frame appears only after the next frame_start.
  - If halt is first sampled in the same cycle as frame_start, shown takes the live values. These equal the values frozen in that cycle, so the result is consistent.
- Output registers (every cycle after reset):
  - an <= ~(8'b1 << digit_idx).
  - seg[6:0] <= hexdecode(shown[4*digit_idx+3 : 4*digit_idx]).
  - seg[7] <= ~(halt_lat && digit_idx == 0): the dp of digit 0 is lit while halted.
- Latency and timing:
  - an and seg lag digit_idx by one cycle.
  - The first cycle after reset release gives an = 8'hFE and seg = 8'hC0.
- hexdecode table (seg[7:0] with dp off):
  - 0 → C0, 1 → F9, 2 → A4, 3 → B0, 4 → 99, 5 → 92, 6 → 82, 7 → F8
  - 8 → 80, 9 → 90, A → 88, b → 83, C → C6, d → A1, E → 86, F → 8E
- Reset mid-frame: all state returns to reset values immediately. Scan restarts at digit 0 and shows 0 until the first frame_start.
- Exactly one an bit is low in every cycle after the first post-reset edge.

Test Plan:
- Reset/scan (REFRESH_DIV = 2):
  - Stimulus: hold clr low, then release it.
  - Required: an = FF while clr is low.
  - Required: after release, an steps FE, FE, FD, FD, … 7F, 7F, then FE again.
  - Required: seg = C0 throughout the first frame.
- Snapshot (REFRESH_DIV = 2, mode = 0):
  - Stimulus: display = 32'h1234ABCD, held until after the first frame_start.
  - Required frame-2 seg sequence, digit 0 through digit 7: A1, C6, 83, 88, 99, B0, A4, F9.
  - Stimulus: change display to 32'h0 mid-frame 2.
  - Required: frame 2 is unchanged; frame 3 shows all C0.
- Mode switch:
  - Stimulus: mode = 1, cycle_count = 32'h00000010, set mid-frame.
  - Required: after the next frame_start, digit 1 shows F9, all other digits show C0.
- Halt freeze:
  - Stimulus: display = 32'h5, cycle_count = 32'h99, pulse halt for one cycle; then change the inputs to 32'hFFFFFFFF.
  - Required: halted = 1 on the next cycle and stays 1.
  - Required: shown stays 5 with mode = 0 and 99 with mode = 1.
  - Required: digit 0 seg = 12 while mode = 0 (5 with dp lit).
- Halt coincident with frame_start:
  - Stimulus: assert halt in the frame_start cycle with display = 32'h7.
  - Required: shown = 7 and frozen_disp = 7.
- Reset mid-operation:
  - Stimulus: while halted at digit 4, pull clr low.
  - Required: halted = 0 and an = FF immediately.
  - Required: after release, the scan restarts at an = FE with seg = C0.

Source files
------------

// File: rtl/cpu_seg_display.sv
// Multiplexed 8-digit common-anode seven-segment driver for the CPU status outputs.
// The shown value is snapshotted once per scan frame; a halt freezes both sources.
module cpu_seg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] display,
    input  logic [31:0] cycle_count,
    input  logic        halt,
    input  logic        mode,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        halted
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       digit_idx;
    logic [31:0]      shown;
    logic [31:0]      frozen_disp;
    logic [31:0]      frozen_cyc;
    logic             halt_lat;

    logic             tick;
    logic             frame_start;
    logic [31:0]      src;
    logic [3:0]       nibble;

    // Returns seg[6:0] = g,f,e,d,c,b,a, active-low.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick        = (div_cnt == DIV_LAST);
    assign frame_start = tick && (digit_idx == 3'd7);
    assign src         = halt_lat ? (mode ? frozen_cyc : frozen_disp)
                                  : (mode ? cycle_count : display);
    assign nibble      = shown[4*digit_idx +: 4];
    assign halted      = halt_lat;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_cnt   <= '0;
            digit_idx <= 3'd0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                digit_idx <= digit_idx + 3'd1;
        end
    end

    // Live values sampled on the halt cycle equal the frozen ones, so a halt
    // coinciding with frame_start still snapshots a consistent value.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            halt_lat    <= 1'b0;
            frozen_disp <= '0;
            frozen_cyc  <= '0;
            shown       <= '0;
        end else begin
            if (halt && !halt_lat) begin
                halt_lat    <= 1'b1;
                frozen_disp <= display;
                frozen_cyc  <= cycle_count;
            end
            if (frame_start)
                shown <= src;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= ~(8'b1 << digit_idx);
            seg <= {~(halt_lat && (digit_idx == 3'd0)), hex7(nibble)};
        end
    end

endmodule

// File: tb/tb_cpu_seg_display.sv
// Directed bench for cpu_seg_display with REFRESH_DIV = 2 (each digit lit for two cycles).
module tb_cpu_seg_display;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] display;
    logic [31:0] cycle_count;
    logic        halt;
    logic        mode;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    cpu_seg_display #(.REFRESH_DIV(2)) dut (
        .clk         (clk),
        .clr         (clr),
        .display     (display),
        .cycle_count (cycle_count),
        .halt        (halt),
        .mode        (mode),
        .an          (an),
        .seg         (seg),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Posedges since the last reset release; output k shows digit ((k-1)/2)%8.
    always @(posedge clk or negedge clr) begin
        if (!clr) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (cyc < k && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != k) begin
            checks++;
            errors++;
            $error("FAIL wait_cyc: observed cycle %0d expected %0d", cyc, k);
        end
    endtask

    task automatic chk_range(input int kf, input int kt, input logic [31:0] val, input bit dp);
        for (int k = kf; k <= kt; k++) begin
            int d;
            logic [7:0] exp_an;
            logic [7:0] exp_seg;
            logic [3:0] nib;
            wait_cyc(k);
            d = ((k - 1) / 2) % 8;
            exp_an = 8'hFF;
            exp_an[d] = 1'b0;
            nib = val[4*d +: 4];
            exp_seg = hex_tab[nib];
            if (dp && d == 0) exp_seg[7] = 1'b0;
            check8($sformatf("an k=%0d", k), an, exp_an);
            check8($sformatf("seg k=%0d d=%0d", k, d), seg, exp_seg);
        end
    endtask

    initial begin
        clr = 1'b0;
        display = '0;
        cycle_count = '0;
        halt = 1'b0;
        mode = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check8("reset an", an, 8'hFF);
            check8("reset seg", seg, 8'hFF);
            check1("reset halted", halted, 1'b0);
        end

        // Scan from reset, then snapshot of display
        clr = 1'b1;
        display = 32'h1234ABCD;
        chk_range(1, 16, 32'h0, 1'b0);
        chk_range(17, 24, 32'h1234ABCD, 1'b0);
        display = 32'h0;
        chk_range(25, 32, 32'h1234ABCD, 1'b0);
        chk_range(33, 40, 32'h0, 1'b0);

        // Mode switch mid-frame
        mode = 1'b1;
        cycle_count = 32'h00000010;
        chk_range(41, 48, 32'h0, 1'b0);
        chk_range(49, 66, 32'h10, 1'b0);

        // Halt pulse then input change
        display = 32'h5;
        cycle_count = 32'h99;
        halt = 1'b1;
        wait_cyc(67);
        halt = 1'b0;
        check1("halted after pulse", halted, 1'b1);
        display = 32'hFFFFFFFF;
        cycle_count = 32'hFFFFFFFF;
        chk_range(67, 80, 32'h10, 1'b1);
        chk_range(81, 88, 32'h99, 1'b1);
        mode = 1'b0;
        chk_range(89, 96, 32'h99, 1'b1);
        chk_range(97, 105, 32'h5, 1'b1);
        check1("halted sticky", halted, 1'b1);

        // Reset while halted at digit 4
        clr = 1'b0;
        #1;
        check1("midreset halted", halted, 1'b0);
        check8("midreset an", an, 8'hFF);
        check8("midreset seg", seg, 8'hFF);
        @(negedge clk);
        check8("midreset held an", an, 8'hFF);
        clr = 1'b1;
        display = 32'h7;
        mode = 1'b0;
        wait_cyc(1);
        check8("restart an", an, 8'hFE);
        check8("restart seg", seg, 8'hC0);
        check1("restart halted", halted, 1'b0);

        // Halt coincident with frame_start (edge 16)
        chk_range(2, 15, 32'h0, 1'b0);
        halt = 1'b1;
        chk_range(16, 16, 32'h0, 1'b0);
        halt = 1'b0;
        check1("coincident halted", halted, 1'b1);
        display = 32'hFFFFFFFF;
        chk_range(17, 32, 32'h7, 1'b1);
        chk_range(33, 48, 32'h7, 1'b1);
        check1("coincident halted sticky", halted, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
